fir_pack_fifo: RTL
==================

Name: fir_pack_fifo

Overview:
Output-side width converter for the FIR sample stream, and the counterpart of the 512-to-8-bit input FIFO. It accepts one 8-bit filtered sample per cycle and packs 64 consecutive samples into one 512-bit cache line. Completed lines are buffered in a line FIFO for the AFU write path. A flush request closes a partially filled line, zero-padded, so the tail of a job can be written out.

Parameters:
FIR_PACK_LINES, 8, depth of the line FIFO in 512-bit entries; must be a power of two, >= 2.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
enq_data  input  8  sample byte to pack
enq_en  input  1  byte write request; accepted when enq_en && not_full
not_full  output  1  byte side can accept a byte this cycle
flush  input  1  single-cycle request to close the current partial line
flush_done  output  1  one-cycle pulse when the flush has completed
deq_data  output  512  head line (show-ahead; valid while not_empty)
deq_bytes  output  7  valid bytes in the head line, 1..64
deq_en  input  1  pop head line; honoured when deq_en && not_empty
not_empty  output  1  line FIFO holds at least one line
line_count  output  $clog2(FIR_PACK_LINES)+1  lines currently held in the line FIFO

Behaviour:
- Reset (asynchronous, active-high):
  - Clears the staging buffer, byte_idx (6 bits), write and read pointers, line_count and the state register.
  - Staged bytes are discarded.
  - Outputs after reset: not_full=1, not_empty=0, flush_done=0, line_count=0, deq_bytes=0, deq_data=0.
- Byte lanes: an accepted byte is written to staging lane [8*byte_idx +: 8], then byte_idx increments. The first byte of a line lands in bits [7:0].
- Line push:
  - When a byte is accepted at byte_idx==63, the completed line (staging plus that byte) is written to the line FIFO in the same edge, with deq_bytes=64.
  - byte_idx wraps to 0 and the staging buffer clears.
  - The pushed line is visible at not_empty/deq_data on the next cycle.
- not_full:
  - Equals 0 when byte_idx==63 and line_count==FIR_PACK_LINES.
  - Equals 0 in state S_FLUSH.
  - Equals 1 otherwise.
  - Depends on registered state only; a same-cycle pop does not create space.
- Dequeue:
  - deq_data and deq_bytes are read combinationally from mem[rd_ptr].
  - A pop advances rd_ptr modulo FIR_PACK_LINES. A pop when empty is ignored.
- line_count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. It never exceeds FIR_PACK_LINES.
- State machine:
  - S_FILL (reset state):
    - flush with byte_idx==0 after any same-cycle byte: pulse flush_done next cycle, stay in S_FILL.
    - flush with byte_idx!=0 and line FIFO not full: push the zero-padded line with deq_bytes=byte_idx, clear byte_idx, pulse flush_done next cycle.
    - flush with byte_idx!=0 and line FIFO full: go to S_FLUSH.
  - S_FLUSH:
    - Bytes are refused and further flush inputs are ignored.
    - When line_count<FIR_PACK_LINES, push the padded line, return to S_FILL, pulse flush_done.
- Simultaneous enq and flush: the byte is accepted first and is included in the flushed line. If that byte completes a 64-byte line, the full line is pushed, no extra partial line is produced, and flush_done pulses.
- Padding: unused lanes of a flushed line read as 8'h00.
- Pointer wrap: write and read pointers wrap modulo FIR_PACK_LINES. Full and empty are distinguished by line_count.

Optional Feature:
FIR_PACK_STATS_EN:
- Defined: adds output total_lines (32 bits), counting every line pushed since reset, full and partial, and saturating at 32'hFFFFFFFF. Also adds output pad_bytes (32 bits), accumulating 64-deq_bytes for each flushed partial line. Both reset to 0.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- Bytes 0x00..0x3F on 64 consecutive cycles -> next cycle not_empty=1, deq_bytes=64, deq_data[7:0]=00, deq_data[511:504]=3F, line_count=1.
- 10 bytes 0xA0..0xA9 then flush -> one line pushed, deq_bytes=10, lanes 0..9 = A0..A9, lanes 10..63 = 0, flush_done pulses once.
- Fill 8 lines (DEPTH=8) plus 63 bytes, with no pops -> not_full=0. One pop -> not_full=1 the following cycle. The 64th byte then completes line 9, line_count=8.
- Line FIFO full, 5 staged bytes, flush -> S_FLUSH, not_full=0, no flush_done. Pop once -> padded line pushed, flush_done pulses, not_full=1.
- Byte 63 of a line and flush in the same cycle -> one full line (deq_bytes=64), no empty partial line, flush_done=1. Flush with byte_idx==0 -> flush_done only, line_count unchanged.
- Assert reset mid-line (30 bytes staged, 3 lines held) -> not_empty=0, line_count=0, not_full=1 immediately. The next 64 bytes form a line starting at lane 0.

Source files
------------

// File: rtl/fir_pack_fifo.sv
// ============================================================================
// Module   : fir_pack_fifo
// Purpose  : Packs 8-bit FIR output samples into 512-bit cache lines and
//            buffers completed lines in a show-ahead line FIFO. A flush
//            request closes a partial line, zero-padded.
//            Optional build macro FIR_PACK_STATS_EN adds total_lines and
//            pad_bytes statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_pack_fifo #(
  parameter int FIR_PACK_LINES = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [7:0]                        enq_data,
  input  logic                              enq_en,
  output logic                              not_full,
  input  logic                              flush,
  output logic                              flush_done,
  output logic [511:0]                      deq_data,
  output logic [6:0]                        deq_bytes,
  input  logic                              deq_en,
  output logic                              not_empty,
  output logic [$clog2(FIR_PACK_LINES):0]   line_count
`ifdef FIR_PACK_STATS_EN
  ,
  output logic [31:0]                       total_lines,
  output logic [31:0]                       pad_bytes
`endif
);

  localparam int PW = $clog2(FIR_PACK_LINES);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(FIR_PACK_LINES);

  typedef enum logic [0:0] {S_FILL = 1'b0, S_FLUSH = 1'b1} state_t;

  logic [511:0] r_stage;
  logic [5:0]   r_idx;
  logic [511:0] r_mem       [FIR_PACK_LINES];
  logic [6:0]   r_mem_bytes [FIR_PACK_LINES];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic          r_flush_done;

  logic          w_full;
  logic          w_not_full;
  logic          w_acc;
  logic          w_pop;
  logic [511:0]  w_line;
  logic [5:0]    w_idx_next;
  logic          w_push;
  logic [6:0]    w_push_bytes;
  logic          w_clear;
  logic          w_flush_done;
  state_t        w_state_next;

  assign w_full     = (r_count == C_DEPTH);
  // Only registered state gates the byte side; a same-cycle pop never frees room.
  assign w_not_full = (r_state == S_FILL) && !((r_idx == 6'd63) && w_full);
  assign w_acc      = enq_en && w_not_full;
  assign w_pop      = deq_en && (r_count != '0);

  // Merge the incoming byte into staging and decide push / flush handling.
  always_comb begin
    w_line       = r_stage;
    w_idx_next   = r_idx;
    w_push       = 1'b0;
    w_push_bytes = 7'd64;
    w_clear      = 1'b0;
    w_flush_done = 1'b0;
    w_state_next = r_state;
    if (w_acc) begin
      w_line[8*r_idx +: 8] = enq_data;
      w_idx_next           = r_idx + 6'd1;
    end
    case (r_state)
      S_FILL: begin
        if (w_acc && (r_idx == 6'd63)) begin
          // Completed line; a coincident flush has nothing left to close.
          w_push       = 1'b1;
          w_clear      = 1'b1;
          w_flush_done = flush;
        end else if (flush) begin
          if (w_idx_next == 6'd0) begin
            w_flush_done = 1'b1;
          end else if (!w_full) begin
            w_push       = 1'b1;
            w_push_bytes = {1'b0, w_idx_next};
            w_clear      = 1'b1;
            w_flush_done = 1'b1;
          end else begin
            w_state_next = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (!w_full) begin
          w_push       = 1'b1;
          w_push_bytes = {1'b0, r_idx};
          w_clear      = 1'b1;
          w_flush_done = 1'b1;
          w_state_next = S_FILL;
        end
      end
      default: w_state_next = S_FILL;
    endcase
  end

  // Control state: staging, byte index, pointers, occupancy and FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage      <= '0;
      r_idx        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_state      <= S_FILL;
      r_flush_done <= 1'b0;
    end else begin
      r_stage      <= w_clear ? '0 : w_line;
      r_idx        <= w_clear ? '0 : w_idx_next;
      r_state      <= w_state_next;
      r_flush_done <= w_flush_done;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Line storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]       <= w_line;
      r_mem_bytes[r_wr_ptr] <= w_push_bytes;
    end
  end

  assign not_full   = w_not_full;
  assign not_empty  = (r_count != '0);
  assign flush_done = r_flush_done;
  assign line_count = r_count;
  assign deq_data   = not_empty ? r_mem[r_rd_ptr] : '0;
  assign deq_bytes  = not_empty ? r_mem_bytes[r_rd_ptr] : '0;

`ifdef FIR_PACK_STATS_EN
  logic [31:0] r_total_lines;
  logic [31:0] r_pad_bytes;

  // Line and padding statistics since reset; line total saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total_lines <= '0;
      r_pad_bytes   <= '0;
    end else if (w_push) begin
      if (r_total_lines != 32'hFFFF_FFFF) r_total_lines <= r_total_lines + 32'd1;
      r_pad_bytes <= r_pad_bytes + 32'(7'd64 - w_push_bytes);
    end
  end

  assign total_lines = r_total_lines;
  assign pad_bytes   = r_pad_bytes;
`endif

endmodule

`default_nettype wire
